// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter sharing the register-file write port among ALU, load unit and debug
// Grants are combinational from the valids and ptr_q; the write-port outputs are registered.
module rf_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [ADDR_W-1:0]        alu_rd,
   input  logic [DATA_W-1:0]        alu_wd,
   output logic                     alu_ready,
   input  logic                     mem_valid,
   input  logic [ADDR_W-1:0]        mem_rd,
   input  logic [DATA_W-1:0]        mem_wd,
   output logic                     mem_ready,
   input  logic                     dbg_valid,
   input  logic [ADDR_W-1:0]        dbg_rd,
   input  logic [DATA_W-1:0]        dbg_wd,
   output logic                     dbg_ready,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_rd,
   output logic [DATA_W-1:0]        rf_wd,
   output logic [(1<<ADDR_W)-1:0]   pending
);

   localparam int NREQ = 3;

   logic [1:0]        ptr_q, ptr_d;
   logic [3:0]        req_valid;
   logic [2:0]        grant;
   logic [1:0]        gnt_idx;
   logic              gnt_any;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_wd;
   logic              rf_we_q;
   logic [ADDR_W-1:0] rf_rd_q;
   logic [DATA_W-1:0] rf_wd_q;

   // Bit 3 is a constant-zero pad so a 2-bit candidate index never selects out of range.
   assign req_valid = {1'b0, dbg_valid, mem_valid, alu_valid};

   always_comb begin
      int   c;
      logic [1:0] cand;
      grant   = '0;
      gnt_idx = 2'd0;
      gnt_any = 1'b0;
      c       = 0;
      cand    = 2'd0;
      for (int k = 0; k < NREQ; k++) begin
         c = int'(ptr_q) + k;
         if (c >= NREQ) begin
            c = c - NREQ;
         end
         cand = 2'(c);
         if (!gnt_any && !rst && req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
      if (gnt_any) begin
         case (gnt_idx)
            2'd1:    grant = 3'b010;
            2'd2:    grant = 3'b100;
            default: grant = 3'b001;
         endcase
      end
   end

   assign alu_ready = grant[0];
   assign mem_ready = grant[1];
   assign dbg_ready = grant[2];

   always_comb begin
      sel_rd = alu_rd;
      sel_wd = alu_wd;
      case (gnt_idx)
         2'd1: begin
            sel_rd = mem_rd;
            sel_wd = mem_wd;
         end
         2'd2: begin
            sel_rd = dbg_rd;
            sel_wd = dbg_wd;
         end
         default: begin
            sel_rd = alu_rd;
            sel_wd = alu_wd;
         end
      endcase
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) begin
         ptr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= 2'd0;
         rf_we_q <= 1'b0;
         rf_rd_q <= '0;
         rf_wd_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         rf_we_q <= gnt_any && (sel_rd != '0);
         if (gnt_any) begin
            rf_rd_q <= sel_rd;
            rf_wd_q <= sel_wd;
         end
      end
   end

   // A write staged before reset is dropped in the reset cycle itself, so reg_file never commits it.
   assign rf_we = rf_we_q && !rst;
   assign rf_rd = rf_rd_q;
   assign rf_wd = rf_wd_q;

   always_comb begin
      pending = '0;
      if (alu_valid) pending[alu_rd] = 1'b1;
      if (mem_valid) pending[mem_rd] = 1'b1;
      if (dbg_valid) pending[dbg_rd] = 1'b1;
      if (rf_we)     pending[rf_rd_q] = 1'b1;
      pending[0] = 1'b0;
   end

endmodule
